// File: rtl/bombe_pkg.sv
// Shared encodings for the bombe step scheduler: FSM states, rate codes, search length.
// Pure declarations, no logic or timing.
package bombe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [1:0] RATE_FULL = 2'b00;
    localparam logic [1:0] RATE_4HZ  = 2'b01;
    localparam logic [1:0] RATE_1HZ  = 2'b10;
    localparam logic [1:0] RATE_QHZ  = 2'b11;

    // Three rotors of 26 letters each.
    localparam int unsigned POS_MAX_DEFAULT = 26 * 26 * 26 - 1;

endpackage

// File: rtl/bombe_tick_counter.sv
// Period counter: terminal is combinational off the count register, asserted while count >= period-1.
// Counts only while enabled; synchronous clear wins over enable; no backpressure.
module bombe_tick_counter #(
    parameter int unsigned PER_W = 28
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    output logic             terminal
);

    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // >= rather than == so a switch to a shorter period fires immediately.
    assign terminal = (cnt_q >= (period - PER_W'(1)));

endmodule

// File: rtl/bombe_step_scheduler.sv
// Bombe search sequencer: one-cycle step enables at a selectable rate, walking position 0..POS_MAX.
// Outputs registered (1-cycle); each step waits on step_ack from the core before the next is issued.
module bombe_step_scheduler
    import bombe_pkg::*;
#(
    parameter int unsigned PER_W    = 28,
    parameter int unsigned PERIOD_0 = 1,
    parameter int unsigned PERIOD_1 = 12500000,
    parameter int unsigned PERIOD_2 = 50000000,
    parameter int unsigned PERIOD_3 = 200000000,
    parameter int unsigned POS_W    = 15,
    parameter int unsigned POS_MAX  = POS_MAX_DEFAULT
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             single_step,
    input  logic             clear,
    input  logic [1:0]       rate_sel,
    input  logic             step_ack,
    input  logic             ack_hit,
    output logic             step,
    output logic [POS_W-1:0] position,
    output logic [2:0]       state_o,
    output logic             hit_found,
    output logic             done
);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    state_t           ret_eff;
    logic             step_q, step_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             hit_q, hit_d;
    logic             done_q, done_d;

    logic [PER_W-1:0] period;
    logic             tick_term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             at_last;

    always_comb begin
        period = PER_W'(PERIOD_0);
        case (rate_sel)
            RATE_FULL: period = PER_W'(PERIOD_0);
            RATE_4HZ:  period = PER_W'(PERIOD_1);
            RATE_1HZ:  period = PER_W'(PERIOD_2);
            RATE_QHZ:  period = PER_W'(PERIOD_3);
            default:   period = PER_W'(PERIOD_0);
        endcase
    end

    // Held at zero outside RUN, so every entry into RUN starts a fresh period.
    assign cnt_en  = (state_q == ST_RUN);
    assign cnt_clr = clear || stop || tick_term || (state_q != ST_RUN);

    bombe_tick_counter #(
        .PER_W (PER_W)
    ) u_tick (
        .clk_in   (clk_in),
        .resetn   (resetn),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .period   (period),
        .terminal (tick_term)
    );

    assign at_last = (pos_q == POS_W'(POS_MAX));

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        ret_eff = ret_q;
        step_d  = 1'b0;
        pos_d   = pos_q;
        hit_d   = hit_q;
        done_d  = done_q;

        if (clear) begin
            state_d = ST_IDLE;
            ret_d   = ST_RUN;
            pos_d   = '0;
            hit_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (!stop) begin
                        if (start) begin
                            state_d = ST_RUN;
                        end else if (single_step) begin
                            step_d  = 1'b1;
                            state_d = ST_WAIT_ACK;
                            ret_d   = ST_PAUSED;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (tick_term) begin
                        step_d  = 1'b1;
                        state_d = ST_WAIT_ACK;
                        ret_d   = ST_RUN;
                    end
                end
                ST_WAIT_ACK: begin
                    ret_eff = stop ? ST_PAUSED : ret_q;
                    ret_d   = ret_eff;
                    // The cycle carrying step itself cannot hold a valid ack.
                    if (!step_q && step_ack) begin
                        if (ack_hit) begin
                            state_d = ST_HALT;
                            hit_d   = 1'b1;
                            done_d  = at_last;
                        end else if (at_last) begin
                            state_d = ST_HALT;
                            done_d  = 1'b1;
                        end else begin
                            pos_d   = pos_q + POS_W'(1);
                            state_d = ret_eff;
                        end
                    end
                end
                ST_HALT: begin
                    if (!stop && start && hit_q && !done_q) begin
                        hit_d   = 1'b0;
                        pos_d   = pos_q + POS_W'(1);
                        state_d = ST_RUN;
                        ret_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_RUN;
            step_q  <= 1'b0;
            pos_q   <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            step_q  <= step_d;
            pos_q   <= pos_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    assign step      = step_q;
    assign position  = pos_q;
    assign state_o   = state_q;
    assign hit_found = hit_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bombe_step_scheduler.sv
// Directed bench for bombe_step_scheduler with a per-cycle reference model and literal timing checks.
module tb_bombe_step_scheduler;

    localparam int PMAX = 5;
    localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_PAUSED = 3, S_HALT = 4;

    logic        clk_in = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0, stop = 1'b0, single_step = 1'b0, clear = 1'b0;
    logic [1:0]  rate_sel = 2'b00;
    logic        step_ack = 1'b0, ack_hit = 1'b0;
    logic        step;
    logic [14:0] position;
    logic [2:0]  state_o;
    logic        hit_found, done;

    bombe_step_scheduler #(
        .PER_W    (28),
        .PERIOD_0 (1),
        .PERIOD_1 (4),
        .PERIOD_2 (8),
        .PERIOD_3 (16),
        .POS_W    (15),
        .POS_MAX  (PMAX)
    ) dut (
        .clk_in      (clk_in),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .single_step (single_step),
        .clear       (clear),
        .rate_sel    (rate_sel),
        .step_ack    (step_ack),
        .ack_hit     (ack_hit),
        .step        (step),
        .position    (position),
        .state_o     (state_o),
        .hit_found   (hit_found),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    int steps[$];
    int ack_at  = -100;
    int lat     = 2;
    int hit_pos = 99;
    bit auto_ack = 1'b1;
    bit mdl_on   = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Step log and core ack scheduling: ack is presented lat cycles after step.
    always @(negedge clk_in) begin
        if (step === 1'b1) begin
            steps.push_back(cyc - base);
            ack_at <= cyc + lat;
        end
    end

    initial forever begin
        @(posedge clk_in);
        #1;
        if (auto_ack) begin
            step_ack = (cyc == ack_at);
            ack_hit  = (cyc == ack_at) && (int'(position) == hit_pos);
        end
    end

    // Reference model: mode, position and flags tracked as plain integers.
    int m_mode, m_pos, m_runcyc;
    bit m_step, m_hit, m_done, m_to_pause, m_stepped_last;

    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 8;
            default: return 16;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = S_IDLE; m_pos = 0; m_runcyc = 0;
        m_step = 0; m_hit = 0; m_done = 0; m_to_pause = 0;
    endtask

    initial forever begin
        @(posedge clk_in or negedge resetn);
        if (!resetn) begin
            model_reset();
        end else begin
            m_stepped_last = m_step;
            m_step = 0;
            if (clear) begin
                model_reset();
            end else if (m_mode == S_IDLE || m_mode == S_PAUSED) begin
                if (!stop && start) begin
                    m_mode = S_RUN; m_runcyc = 0;
                end else if (!stop && single_step) begin
                    m_mode = S_WAIT; m_step = 1; m_to_pause = 1;
                end
            end else if (m_mode == S_RUN) begin
                if (stop) m_mode = S_PAUSED;
                else if (m_runcyc + 1 >= period_of(rate_sel)) begin
                    m_mode = S_WAIT; m_step = 1; m_to_pause = 0;
                end else m_runcyc++;
            end else if (m_mode == S_WAIT) begin
                if (stop) m_to_pause = 1;
                if (!m_stepped_last && step_ack) begin
                    if (ack_hit || m_pos == PMAX) begin
                        m_mode = S_HALT;
                        m_hit  = ack_hit;
                        m_done = (m_pos == PMAX);
                    end else begin
                        m_pos++;
                        m_mode = m_to_pause ? S_PAUSED : S_RUN;
                        m_runcyc = 0;
                    end
                end
            end else if (m_mode == S_HALT) begin
                if (!stop && start && m_hit && !m_done) begin
                    m_hit = 0; m_pos++; m_mode = S_RUN; m_runcyc = 0; m_to_pause = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (mdl_on) begin
            total++;
            if (int'(state_o) != m_mode || step !== m_step || int'(position) != m_pos ||
                hit_found !== m_hit || done !== m_done) begin
                bad++;
                $display("FAIL model cyc=%0d got st=%0d step=%0b pos=%0d hit=%0b done=%0b expected st=%0d step=%0b pos=%0d hit=%0b done=%0b",
                         cyc, state_o, step, position, hit_found, done,
                         m_mode, m_step, m_pos, m_hit, m_done);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // kind 0: state_o==val, kind 1: step high at position val, kind 2: done==val
    task automatic wait_for(input string nm, input int kind, input int val, input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            case (kind)
                0: ok = (int'(state_o) == val);
                1: ok = (step === 1'b1) && (int'(position) == val);
                default: ok = (int'(done) == val);
            endcase
            if (!ok) tick();
        end
        check({"wait_", nm}, int'(ok), 1);
    endtask

    // 0 start, 1 stop, 2 single_step, 3 clear
    task automatic pulse(input int which);
        case (which)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: single_step = 1'b1;
            default: clear = 1'b1;
        endcase
        tick();
        start = 1'b0; stop = 1'b0; single_step = 1'b0; clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_state", int'(state_o), S_IDLE);
        check("rst_step", int'(step), 0);
        check("rst_pos", int'(position), 0);
        check("rst_flags", int'({hit_found, done}), 0);
        resetn = 1'b1;
        mdl_on = 1'b1;
        tick();

        // Run timing at P=4, L=2 through exhaustion.
        rate_sel = 2'b01; lat = 2; steps.delete();
        base = cyc;
        pulse(0);
        wait_for("done", 2, 1, 150);
        tick();
        check("run_nsteps", steps.size(), PMAX + 1);
        for (int i = 0; i < steps.size() && i <= PMAX; i++)
            check("run_step_cycle", steps[i], 5 + 7 * i);
        check("run_done_pos", int'(position), PMAX);
        check("run_done_hit", int'(hit_found), 0);
        repeat (20) tick();
        check("run_no_more_steps", steps.size(), PMAX + 1);

        // Hit at position 3, then resume.
        pulse(3);
        check("clr_state", int'(state_o), S_IDLE);
        check("clr_pos", int'(position), 0);
        steps.delete(); hit_pos = 3;
        pulse(0);
        wait_for("halt", 0, S_HALT, 100);
        check("hit_flag", int'(hit_found), 1);
        check("hit_pos", int'(position), 3);
        check("hit_done", int'(done), 0);
        repeat (50) tick();
        check("hit_quiet", steps.size(), 4);
        hit_pos = 99;
        base = cyc;
        pulse(0);
        check("resume_hit", int'(hit_found), 0);
        check("resume_pos", int'(position), 4);
        wait_for("resume_step", 1, 4, 20);
        check("resume_gap", cyc - base, 5);
        wait_for("resume_done", 2, 1, 60);
        check("resume_done_pos", int'(position), PMAX);

        // Pause via stop in WAIT_ACK, then single steps.
        pulse(3);
        pulse(0);
        wait_for("step_pos1", 1, 1, 40);
        pulse(1);
        wait_for("paused", 0, S_PAUSED, 20);
        check("pause_pos", int'(position), 2);
        steps.delete();
        pulse(2);
        repeat (8) tick();
        check("ss_nsteps", steps.size(), 1);
        check("ss_state", int'(state_o), S_PAUSED);
        check("ss_pos", int'(position), 3);
        pulse(1); pulse(1); pulse(1);
        repeat (4) tick();
        check("stop_ignored_state", int'(state_o), S_PAUSED);
        check("stop_ignored_steps", steps.size(), 1);

        // Priority, full speed, clear during WAIT_ACK.
        pulse(3);
        steps.delete();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (5) tick();
        check("prio_state", int'(state_o), S_IDLE);
        check("prio_nsteps", steps.size(), 0);
        rate_sel = 2'b00; lat = 1;
        base = cyc;
        pulse(0);
        wait_for("fs0", 1, 0, 10);
        check("fs_step0", cyc - base, 2);
        tick();
        wait_for("fs1", 1, 1, 10);
        check("fs_step1", cyc - base, 5);
        tick();
        wait_for("fs2", 1, 2, 10);
        check("fs_step2", cyc - base, 8);
        tick(); tick();
        auto_ack = 1'b0;
        wait_for("fs3", 1, 3, 10);
        pulse(3);
        check("clr_wait_state", int'(state_o), S_IDLE);
        check("clr_wait_pos", int'(position), 0);
        step_ack = 1'b1; ack_hit = 1'b1;
        tick();
        step_ack = 1'b0; ack_hit = 1'b0;
        repeat (3) tick();
        check("late_ack_state", int'(state_o), S_IDLE);
        check("late_ack_hit", int'(hit_found), 0);
        auto_ack = 1'b1;

        // Asynchronous reset between edges while step is high.
        lat = 2;
        pulse(0);
        wait_for("pre_rst", 1, 2, 40);
        #2 resetn = 1'b0;
        #1;
        check("arst_step", int'(step), 0);
        check("arst_pos", int'(position), 0);
        check("arst_flags", int'({hit_found, done}), 0);
        check("arst_state", int'(state_o), S_IDLE);
        #2 resetn = 1'b1;
        repeat (10) tick();
        check("post_rst_state", int'(state_o), S_IDLE);

        // Rate change from P=16 to P=4 with counter at 10.
        rate_sel = 2'b11;
        base = cyc;
        pulse(0);
        repeat (10) tick();
        rate_sel = 2'b01;
        wait_for("rc0", 1, 0, 5);
        check("rate_change_fire", cyc - base, 12);
        tick();
        wait_for("rc1", 1, 1, 20);
        check("rate_change_next", cyc - base, 19);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
